// File: rtl/stream_switch_pkg.sv
// Shared types and defaults for the demux switchover sequencer.
package stream_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EOP,
    ST_DRAIN,
    ST_SWITCH
  } sw_state_e;

  localparam int unsigned DEFAULT_DRAIN_CYCLES   = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  // Width of a down/up counter that must hold the value n (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/stream_pkt_tracker.sv
// Tracks whether the monitored stream is between the first and last beat of a packet.
// With SWITCH_TIMEOUT_EN defined, a clear input discards a packet abandoned by a forced switch.
module stream_pkt_tracker (
  input  logic clk_i,
  input  logic rst_i,
`ifdef SWITCH_TIMEOUT_EN
  input  logic clr_i,
`endif
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic in_packet_o
);

  logic in_packet_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_packet_q <= 1'b0;
`ifdef SWITCH_TIMEOUT_EN
    end else if (clr_i) begin
      in_packet_q <= 1'b0;
`endif
    end else if (tvalid_i && tready_i) begin
      in_packet_q <= !tlast_i;
    end
  end

  assign in_packet_o = in_packet_q;

endmodule

// File: rtl/demux_switchover_sequencer.sv
// Sequences a demux select change at a packet boundary: wait for end of packet, drain, switch.
// Optional macro SWITCH_TIMEOUT_EN forces the switch if the end of packet never arrives.
module demux_switchover_sequencer
  import stream_switch_pkg::*;
#(
  parameter int M_COUNT        = 2,
  parameter int CL_M_COUNT     = $clog2(M_COUNT),
  parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int DEFAULT_SELECT = 0
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  req_valid,
  input  logic [CL_M_COUNT-1:0] req_select,
  output logic                  req_ready,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  output logic                  hold,
  output logic [CL_M_COUNT-1:0] select_active,
  output logic                  busy,
  output logic                  switch_done,
  output logic                  timeout_err
);

  localparam int unsigned DCW      = cnt_width(DRAIN_CYCLES);
  localparam sw_state_e   FLUSH_ST = (DRAIN_CYCLES == 0) ? ST_SWITCH : ST_DRAIN;

  sw_state_e             state_q, state_d;
  logic [CL_M_COUNT-1:0] target_q, target_d;
  logic [CL_M_COUNT-1:0] sel_q, sel_d;
  logic [DCW-1:0]        cnt_q, cnt_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  in_packet;
  logic                  eop;

`ifdef SWITCH_TIMEOUT_EN
  localparam int unsigned TCW = cnt_width(TIMEOUT_CYCLES);
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           forced_q, forced_d;
  logic           pkt_clr;
`endif

  assign eop = mon_tvalid && mon_tready && mon_tlast;

  stream_pkt_tracker u_tracker (
    .clk_i       (axis_aclk),
    .rst_i       (axis_areset),
`ifdef SWITCH_TIMEOUT_EN
    .clr_i       (pkt_clr),
`endif
    .tvalid_i    (mon_tvalid),
    .tready_i    (mon_tready),
    .tlast_i     (mon_tlast),
    .in_packet_o (in_packet)
  );

  // Flush states spend their first cycle with hold low (hold_q still 0), so SWITCH
  // exits only once hold has been seen high; this keeps the D+1 hold window uniform.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    hold_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SWITCH_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
    forced_d = forced_q;
    pkt_clr  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SWITCH_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (req_valid) begin
          if (req_select == sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_select;
            cnt_d    = DCW'(DRAIN_CYCLES);
            state_d  = in_packet ? ST_WAIT_EOP : FLUSH_ST;
          end
        end
      end
      ST_WAIT_EOP: begin
        if (eop) begin
          state_d = FLUSH_ST;
          cnt_d   = DCW'(DRAIN_CYCLES);
        end
`ifdef SWITCH_TIMEOUT_EN
        else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = FLUSH_ST;
          cnt_d    = DCW'(DRAIN_CYCLES);
          err_d    = 1'b1;
          forced_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        hold_d = 1'b1;
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SWITCH: begin
        hold_d = 1'b1;
        if (hold_q) begin
          hold_d  = 1'b0;
          state_d = ST_IDLE;
          sel_d   = target_q;
          done_d  = 1'b1;
`ifdef SWITCH_TIMEOUT_EN
          pkt_clr  = forced_q;
          forced_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      sel_q    <= CL_M_COUNT'(DEFAULT_SELECT);
      cnt_q    <= '0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef SWITCH_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
      forced_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef SWITCH_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      forced_q <= forced_d;
`endif
    end
  end

  assign req_ready     = ready_q;
  assign hold          = hold_q;
  assign select_active = sel_q;
  assign busy          = busy_q;
  assign switch_done   = done_q;
`ifdef SWITCH_TIMEOUT_EN
  assign timeout_err   = err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_demux_switchover_sequencer.sv
// Directed bench for demux_switchover_sequencer (DRAIN_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_demux_switchover_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_select = 2'd0;
  logic       req_ready;
  logic       mon_tvalid = 1'b0;
  logic       mon_tready = 1'b1;
  logic       mon_tlast = 1'b0;
  logic       hold;
  logic [1:0] select_active;
  logic       busy;
  logic       switch_done;
  logic       timeout_err;

  int total = 0;
  int bad = 0;

  demux_switchover_sequencer #(
    .M_COUNT        (4),
    .CL_M_COUNT     (2),
    .DRAIN_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .DEFAULT_SELECT (0)
  ) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .req_valid     (req_valid),
    .req_select    (req_select),
    .req_ready     (req_ready),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .hold          (hold),
    .select_active (select_active),
    .busy          (busy),
    .switch_done   (switch_done),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", hold); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (select_active !== 2'd0) begin bad++; $display("FAIL reset_select: got %0d want 0", select_active); end
    total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", switch_done); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  // Idle request 0 -> 1: hold high for 5 cycles, switch at N+6.
  task automatic test_drain_switch;
    req_select = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ds_busy: got %b want 1", busy); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ds_ready: got %b want 0", req_ready); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL ds_hold_n0: got %b want 0", hold); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (hold !== 1'b1) begin bad++; $display("FAIL ds_hold_n%0d: got %b want 1", k, hold); end
      total++; if (select_active !== 2'd0) begin bad++; $display("FAIL ds_sel_n%0d: got %0d want 0", k, select_active); end
      total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL ds_done_n%0d: got %b want 0", k, switch_done); end
    end
    tick();
    total++; if (select_active !== 2'd1) begin bad++; $display("FAIL ds_sel_n6: got %0d want 1", select_active); end
    total++; if (switch_done !== 1'b1) begin bad++; $display("FAIL ds_done_n6: got %b want 1", switch_done); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL ds_hold_n6: got %b want 0", hold); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ds_busy_n6: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ds_ready_n6: got %b want 1", req_ready); end
    tick();
    total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL ds_done_n7: got %b want 0", switch_done); end
  endtask

  // Request for the output already selected.
  task automatic test_noop;
    req_select = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (switch_done !== 1'b1) begin bad++; $display("FAIL noop_done: got %b want 1", switch_done); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL noop_hold: got %b want 0", hold); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL noop_busy: got %b want 0", busy); end
    tick();
    total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL noop_done2: got %b want 0", switch_done); end
    total++; if (select_active !== 2'd1) begin bad++; $display("FAIL noop_sel: got %0d want 1", select_active); end
  endtask

  // Request 1 -> 2 while a packet is open; tlast arrives 10 cycles later.
  task automatic test_mid_packet;
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    tick();
    mon_tvalid = 1'b0;
    req_select = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mp_busy: got %b want 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (hold !== 1'b0) begin bad++; $display("FAIL mp_wait_hold_%0d: got %b want 0", k, hold); end
    end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL mp_err: got %b want 0", timeout_err); end
    mon_tvalid = 1'b1; mon_tlast = 1'b1;
    tick();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL mp_hold_e0: got %b want 0", hold); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++; if (hold !== 1'b1) begin bad++; $display("FAIL mp_hold_e%0d: got %b want 1", k, hold); end
    end
    tick();
    total++; if (select_active !== 2'd2) begin bad++; $display("FAIL mp_sel: got %0d want 2", select_active); end
    total++; if (switch_done !== 1'b1) begin bad++; $display("FAIL mp_done: got %b want 1", switch_done); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL mp_hold_end: got %b want 0", hold); end
  endtask

  // Request 2 -> 3; a second request (to 0) and a packet-start beat arrive during DRAIN.
  task automatic test_back_to_back;
    int done_cnt;
    done_cnt = 0;
    req_select = 2'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin req_valid = 1'b1; req_select = 2'd0; end
      if (k == 3) begin mon_tvalid = 1'b1; mon_tlast = 1'b0; end
      if (k == 4) begin req_valid = 1'b0; mon_tvalid = 1'b0; end
      tick();
      if (switch_done === 1'b1) done_cnt++;
      if (k <= 5) begin
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 0", k, req_ready); end
      end
      if (k == 6) begin
        total++; if (select_active !== 2'd3) begin bad++; $display("FAIL b2b_sel: got %0d want 3", select_active); end
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    total++; if (select_active !== 2'd3) begin bad++; $display("FAIL b2b_sel_final: got %0d want 3", select_active); end
  endtask

  // The beat admitted during hold opened a packet, so this request must wait for tlast.
  task automatic test_hold_beat;
    req_select = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL hb_wait_hold: got %b want 0", hold); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hb_busy: got %b want 1", busy); end
    mon_tvalid = 1'b1; mon_tlast = 1'b1;
    tick();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL hb_hold_e5: got %b want 1", hold); end
    tick();
    total++; if (select_active !== 2'd2) begin bad++; $display("FAIL hb_sel: got %0d want 2", select_active); end
    total++; if (switch_done !== 1'b1) begin bad++; $display("FAIL hb_done: got %b want 1", switch_done); end
  endtask

  // Reset asserted in the middle of DRAIN (2 -> 1 pending).
  task automatic test_reset_mid;
    int done_cnt;
    done_cnt = 0;
    tick();
    req_select = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL rm_pre_hold: got %b want 1", hold); end
    #2 rst = 1'b1;
    #1;
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL rm_hold: got %b want 0", hold); end
    total++; if (select_active !== 2'd0) begin bad++; $display("FAIL rm_sel: got %0d want 0", select_active); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (switch_done === 1'b1) done_cnt++;
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rm_done_count: got %0d want 0", done_cnt); end
    total++; if (select_active !== 2'd0) begin bad++; $display("FAIL rm_sel_after: got %0d want 0", select_active); end
  endtask

`ifdef SWITCH_TIMEOUT_EN
  // Open packet never ends: forced switch after 16 cycles of WAIT_EOP.
  task automatic test_timeout;
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    tick();
    mon_tvalid = 1'b0;
    req_select = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_n15: got %b want 0", timeout_err); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL to_hold_n15: got %b want 0", hold); end
    tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_n16: got %b want 1", timeout_err); end
    tick();
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL to_hold_n17: got %b want 1", hold); end
    for (int k = 0; k < 5; k++) tick();
    total++; if (select_active !== 2'd1) begin bad++; $display("FAIL to_sel: got %0d want 1", select_active); end
    total++; if (switch_done !== 1'b1) begin bad++; $display("FAIL to_done: got %b want 1", switch_done); end
    req_select = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL to_pkt_cleared: got %b want 1", hold); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_reset: got %b want 0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_drain_switch();
    test_noop();
    test_mid_packet();
    test_back_to_back();
    test_hold_beat();
    test_reset_mid();
`ifdef SWITCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_switchover_sequencer.md
DEMUX_SWITCHOVER_SEQUENCER -- requirements
Module: demux_switchover_sequencer

Interface
REQ-001 SHALL have parameter M_COUNT, default 2: number of demux outputs.
REQ-002 SHALL have parameter CL_M_COUNT, default $clog2(M_COUNT): select width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4: idle cycles for the downstream pipeline to flush; 0 is legal.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: wait-for-end-of-packet limit; used only when the timeout feature is compiled in.
REQ-005 SHALL have parameter DEFAULT_SELECT, default 0: select_active value after reset.
REQ-006 axis_aclk  input  1  sole clock.
REQ-007 axis_areset  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  switch request; sampled only when req_ready=1.
REQ-009 req_select  input  CL_M_COUNT  requested demux output.
REQ-010 req_ready  output  1  high only in IDLE.
REQ-011 mon_tvalid, mon_tready, mon_tlast  input  1 each  monitored demux input stream handshake.
REQ-012 hold  output  1  when high, the wrapper forces the input tready low; no new packet is admitted.
REQ-013 select_active  output  CL_M_COUNT  select driving the demux.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 switch_done  output  1  one-cycle pulse on completion, including a no-op request.
REQ-016 timeout_err  output  1  sticky flag for a forced switch.

Function
REQ-017 SHALL define a beat as mon_tvalid && mon_tready; in_packet SHALL set on a beat with mon_tlast=0, clear on a beat with mon_tlast=1, and update in every state.
REQ-018 SHALL use states IDLE, WAIT_EOP, DRAIN, SWITCH; all outputs SHALL be registered.
REQ-019 IDLE: on req_valid with req_select==select_active, the block SHALL stay in IDLE and pulse switch_done on the next cycle.
REQ-020 IDLE: on req_valid with a different req_select, the block SHALL latch the target, go to WAIT_EOP if in_packet=1, else go to DRAIN (SWITCH if DRAIN_CYCLES=0), and assert hold from the next cycle.
REQ-021 WAIT_EOP: hold SHALL be 0; on a beat with mon_tlast=1 the block SHALL go to DRAIN (or SWITCH) and assert hold on the next cycle.
REQ-022 DRAIN: hold SHALL be 1 for exactly DRAIN_CYCLES cycles, counted by a down-counter, then the block SHALL go to SWITCH.
REQ-023 SWITCH: hold SHALL be 1 for one cycle; on exit, select_active SHALL take the target, switch_done SHALL pulse for one cycle, the state SHALL return to IDLE, and hold SHALL fall.
REQ-024 With in_packet=0, a request accepted at edge N SHALL update select_active at edge N+DRAIN_CYCLES+2.
REQ-025 Requests while busy SHALL be ignored (req_ready=0); req_select SHALL NOT be re-sampled.
REQ-026 A beat during hold SHALL still update in_packet but SHALL NOT alter the sequence.

Reset
REQ-027 Asserting axis_areset at any time, including mid-sequence, SHALL force IDLE, select_active=DEFAULT_SELECT, in_packet=0, and hold, busy, switch_done, timeout_err and all counters to 0; a pending target SHALL be discarded.

Configuration
REQ-028 Macro SWITCH_TIMEOUT_EN defined: if WAIT_EOP lasts TIMEOUT_CYCLES cycles without an end-of-packet beat, the block SHALL proceed to DRAIN, set timeout_err until reset, and clear in_packet at SWITCH.
REQ-029 Macro SWITCH_TIMEOUT_EN undefined: WAIT_EOP SHALL wait indefinitely, no timeout counter SHALL exist, and timeout_err SHALL be tied to 0.

Structure
REQ-030 Package stream_switch_pkg SHALL hold the state enum typedef and the default DRAIN_CYCLES and TIMEOUT_CYCLES constants.
REQ-031 The in_packet logic SHALL be sub-module stream_pkt_tracker (inputs: clock, reset, tvalid, tready, tlast; output: in_packet).

Verification
REQ-032 Reset, then req_select=1 while idle with DRAIN_CYCLES=4 -> hold high 5 cycles; select_active=1 and switch_done pulse at edge N+6.
REQ-033 Request while mid-packet, tlast beat 10 cycles later -> hold stays 0 until the tlast beat, then DRAIN, then the switch.
REQ-034 req_select equal to select_active -> no hold, switch_done pulse on the next cycle, state remains IDLE.
REQ-035 Second request during DRAIN -> ignored; the first target applied; exactly one switch_done pulse.
REQ-036 axis_areset asserted during DRAIN -> hold=0, select_active=DEFAULT_SELECT immediately, no switch_done.
REQ-037 SWITCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no tlast -> DRAIN entered after 16 cycles; timeout_err=1 persists until reset.
